fp_alu_scheduler: RTL

- Round-robin scheduler that shares one fp_alu instance between NUM_REQ requesters, such as the keypad command path and the fixed-point conversion path.
- Accepts one operation at a time over a valid/ready handshake and holds operands stable for the whole transaction.
- Issues a single-cycle start pulse to the ALU, waits for done with a watchdog, then returns the result, flags and requester ID as a one-cycle response.

---
 rtl/fp_alu_scheduler_pkg.sv | 39 +++
 rtl/fp_alu_scheduler_if.sv | 44 ++++
 rtl/fp_alu_scheduler_rr_arbiter.sv | 33 +++
 rtl/fp_alu_scheduler.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fp_alu_scheduler_pkg.sv
// Shared definitions for the fp_alu sharing scheduler.
// Contents: ALU opcodes, canonical quiet NaN, response flag bit positions,
// scheduler state encodings and an opcode legality helper.
package fp_alu_scheduler_pkg;

    // Opcodes understood by fp_alu; anything else is rejected by the scheduler.
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_ABS = 4'h4;
    localparam logic [3:0] OP_NEG = 4'h5;
    localparam logic [3:0] OP_MIN = 4'h6;
    localparam logic [3:0] OP_MAX = 4'h7;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    // Bit positions inside rsp_flags.
    localparam int FLAG_OVF = 0;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INV = 2;
    localparam int FLAG_TMO = 3;

    // Scheduler FSM encodings.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV,
            OP_ABS, OP_NEG, OP_MIN, OP_MAX: is_legal_op = 1'b1;
            default:                        is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fp_alu_scheduler_if.sv
// Bundle between requesters/fp_alu (master side) and the scheduler (slave side).
// Signals: per-requester valid/ready/op/a/b, response strobe+payload, busy,
// and the full fp_alu operand/start/result/done/flag connection.
interface fp_alu_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [4*NUM_REQ-1:0]  req_op;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;

    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic [3:0]            rsp_flags;
    logic                  busy;

    logic [31:0]           alu_operand_a;
    logic [31:0]           alu_operand_b;
    logic [3:0]            alu_operation;
    logic                  alu_start;
    logic [31:0]           alu_result;
    logic                  alu_done;
    logic                  alu_overflow;
    logic                  alu_underflow;
    logic                  alu_invalid;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  alu_result, alu_done, alu_overflow, alu_underflow, alu_invalid,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, busy,
        output alu_operand_a, alu_operand_b, alu_operation, alu_start
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output alu_result, alu_done, alu_overflow, alu_underflow, alu_invalid,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, busy,
        input  alu_operand_a, alu_operand_b, alu_operation, alu_start
    );

endinterface

// File: rtl/fp_alu_scheduler_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr_i, wrapping.
// Latency: purely combinational. Backpressure: en_i=0 forces grant_o to zero.
// Ports: req_i request vector, ptr_i search start, en_i enable,
// grant_o one-hot-or-zero grant, id_o encoded index of the grant.
module fp_alu_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    id_o
);

    always_comb begin
        int   idx;
        logic found;
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_i) + i) % NUM_REQ;
            if (en_i && !found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                id_o         = ID_W'(idx);
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_alu_scheduler.sv
// Shares one fp_alu between NUM_REQ requesters, one transaction at a time.
// Latency: accept T -> rsp_valid at T+3+ALU latency (illegal op: T+1; timeout: T+2+TIMEOUT_CYCLES).
// Backpressure: req_ready only in IDLE for the round-robin winner; responses have none.
// Ports: clk, reset (async, active-high), bus (slave modport: requests,
// response strobe/payload, busy, fp_alu drive and return).
module fp_alu_scheduler
    import fp_alu_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    fp_alu_scheduler_if.slave bus
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [ID_W-1:0]    ptr_q,   ptr_d;
    logic [ID_W-1:0]    id_q,    id_d;
    logic [3:0]         op_q,    op_d;
    logic [31:0]        a_q,     a_d;
    logic [31:0]        b_q,     b_d;
    logic [31:0]        res_q,   res_d;
    logic [3:0]         flags_q, flags_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               accept;
    logic [3:0]         sel_op;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;

    // Gating with reset keeps req_ready low while reset is held.
    fp_alu_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .en_i    ((state_q == ST_IDLE) && !reset),
        .grant_o (gnt),
        .id_o    (gnt_id)
    );

    assign accept = |(bus.req_valid & gnt);
    assign sel_op = bus.req_op[4*int'(gnt_id) +: 4];
    assign sel_a  = bus.req_a[32*int'(gnt_id) +: 32];
    assign sel_b  = bus.req_b[32*int'(gnt_id) +: 32];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d  = gnt_id;
                    ptr_d = ID_W'((int'(gnt_id) + 1) % NUM_REQ);
                    if (is_legal_op(sel_op)) begin
                        // Operand registers double as the ALU drive; illegal ops leave them untouched.
                        op_d    = sel_op;
                        a_d     = sel_a;
                        b_d     = sel_b;
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        res_d           = FP_QNAN;
                        flags_d         = '0;
                        flags_d[FLAG_INV] = 1'b1;
                        state_d         = ST_RESP;
                    end
                end
            end
            ST_DRAIN: begin
                // A done left high by the previous op must fall before we start.
                cnt_d = cnt_q + 1'b1;
                if (!bus.alu_done) begin
                    state_d = ST_ISSUE;
                end else if (cnt_q == TMO_LAST) begin
                    res_d             = FP_QNAN;
                    flags_d           = '0;
                    flags_d[FLAG_TMO] = 1'b1;
                    state_d           = ST_RESP;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.alu_done) begin
                    res_d             = bus.alu_result;
                    flags_d           = '0;
                    flags_d[FLAG_OVF] = bus.alu_overflow;
                    flags_d[FLAG_UNF] = bus.alu_underflow;
                    flags_d[FLAG_INV] = bus.alu_invalid;
                    state_d           = ST_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    res_d             = FP_QNAN;
                    flags_d           = '0;
                    flags_d[FLAG_TMO] = 1'b1;
                    state_d           = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready     = gnt;
    assign bus.rsp_valid     = (state_q == ST_RESP);
    assign bus.rsp_id        = id_q;
    assign bus.rsp_result    = res_q;
    assign bus.rsp_flags     = flags_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.alu_operand_a = a_q;
    assign bus.alu_operand_b = b_q;
    assign bus.alu_operation = op_q;
    assign bus.alu_start     = (state_q == ST_ISSUE);

endmodule
